addsub_result_display: RTL and testbench

//  Downstream consumer of the 4-bit add/subtract stage. Captures its 5-bit two's-complement

---
 rtl/addsub_result_display_pkg.sv | 40 ++++
 rtl/addsub_result_display_seg7.sv | 28 ++
 rtl/addsub_result_display.sv | 112 +++++++++++
 tb/tb_addsub_result_display.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/addsub_result_display_pkg.sv
// Shared types and constants for the add/sub result display: FSM states,
// display codes, active-low seven-segment glyphs and the BCD adjust step.
package addsub_result_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Non-digit codes fed to the glyph decoder
  localparam logic [3:0] CODE_MINUS = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;
  localparam logic [3:0] CODE_E     = 4'hE;

  // Glyphs are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_E     = 7'b0000110;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift
  function automatic logic [7:0] bcd_adj(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

endpackage

// File: rtl/addsub_result_display_seg7.sv
// Combinational display code -> active-low seven-segment glyph.
module seg7_decode
  import addsub_result_display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    case (code)
      4'd0:       seg = GLYPH_0;
      4'd1:       seg = GLYPH_1;
      4'd2:       seg = GLYPH_2;
      4'd3:       seg = GLYPH_3;
      4'd4:       seg = GLYPH_4;
      4'd5:       seg = GLYPH_5;
      4'd6:       seg = GLYPH_6;
      4'd7:       seg = GLYPH_7;
      4'd8:       seg = GLYPH_8;
      4'd9:       seg = GLYPH_9;
      CODE_MINUS: seg = GLYPH_MINUS;
      CODE_E:     seg = GLYPH_E;
      default:    seg = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/addsub_result_display.sv
// Captures a signed add/sub result, converts it to sign + two BCD digits with a
// sequential double-dabble, and scans the committed value onto a 3-digit display.
module addsub_result_display
  import addsub_result_display_pkg::*;
#(
  parameter int WIDTH        = 5,
  parameter int REFRESH_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ovf,
  output logic             res_valid,
  output logic             res_sign,
  output logic [3:0]       res_tens,
  output logic [3:0]       res_ones,
  output logic             res_err,
  output logic [6:0]       seg,
  output logic [2:0]       an
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                  state;
  logic [WIDTH-1:0]        mag;
  logic [7:0]              bcd;
  logic [CW-1:0]           cnt;
  logic                    sign_w, err_w;
  logic [REFRESH_BITS-1:0] presc;
  logic [1:0]              idx;
  logic [3:0]              code;

  assign in_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      sign_w    <= 1'b0;
      err_w     <= 1'b0;
      res_valid <= 1'b0;
      res_sign  <= 1'b0;
      res_tens  <= 4'd0;
      res_ones  <= 4'd0;
      res_err   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: if (in_valid) begin
          // Two's-complement negate; the most negative value maps to 2^(W-1) exactly
          mag    <= in_data[WIDTH-1] ? (~in_data + WIDTH'(1)) : in_data;
          sign_w <= in_data[WIDTH-1];
          err_w  <= in_ovf;
          bcd    <= '0;
          cnt    <= CW'(WIDTH);
          state  <= ST_CONV;
        end
        ST_CONV: begin
          {bcd, mag} <= {bcd_adj(bcd), mag} << 1;
          cnt        <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= ST_DONE;
        end
        ST_DONE: begin
          res_valid <= 1'b1;
          res_err   <= err_w;
          res_sign  <= sign_w & ~err_w & (bcd != 8'd0);
          res_tens  <= err_w ? 4'd0 : bcd[7:4];
          res_ones  <= err_w ? 4'd0 : bcd[3:0];
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Digit scan: index 0 = ones, 1 = tens, 2 = sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= 2'd0;
    end else begin
      presc <= presc + REFRESH_BITS'(1);
      if (&presc) idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  always_comb begin
    code = res_err ? CODE_E : res_ones;
    an   = 3'b110;
    case (idx)
      2'd1: begin
        code = res_err ? CODE_E : res_tens;
        an   = 3'b101;
      end
      2'd2: begin
        code = (res_err || res_sign) ? CODE_MINUS : CODE_BLANK;
        an   = 3'b011;
      end
      default: ;
    endcase
  end

  seg7_decode u_dec (
    .code (code),
    .seg  (seg)
  );

endmodule

// File: tb/tb_addsub_result_display.sv
// Directed bench for addsub_result_display: latency, digits, error display,
// back-to-back handshake, scan order and asynchronous reset.
module tb_addsub_result_display;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G6 = 7'b0000010, G7 = 7'b1111000,
                         GM = 7'b0111111, GB = 7'b1111111, GE = 7'b0000110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_ovf;
  logic [4:0] in_data;
  logic       res_valid, res_sign, res_err;
  logic [3:0] res_tens, res_ones;
  logic [6:0] seg;
  logic [2:0] an;

  int total = 0;
  int bad   = 0;

  addsub_result_display #(.WIDTH(5), .REFRESH_BITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ovf    (in_ovf),
    .res_valid (res_valid),
    .res_sign  (res_sign),
    .res_tens  (res_tens),
    .res_ones  (res_ones),
    .res_err   (res_err),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accept one value from IDLE, return cycles from accept edge to res_valid
  task automatic convert(input logic [4:0] d, input logic ov, output int lat);
    lat = -1;
    @(negedge clk);
    chk("rdy_before", in_ready, 1'b1);
    in_valid = 1'b1; in_data = d; in_ovf = ov;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin lat = i; break; end
    end
  endtask

  task automatic check_res(input string tag, input logic s, input logic [3:0] t,
                           input logic [3:0] o, input logic e);
    chk({tag, "_sign"}, res_sign, s);
    chk({tag, "_tens"}, res_tens, t);
    chk({tag, "_ones"}, res_ones, o);
    chk({tag, "_err"},  res_err,  e);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, res_valid, 1'b0);
  endtask

  task automatic scan_chk(input string tag, input logic [6:0] gs, input logic [6:0] gt,
                          input logic [6:0] go);
    int k = 0;
    @(negedge clk);
    while (an !== 3'b110 && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_an0"}, an, 3'b110);
    chk({tag, "_ones"}, seg, go);
    repeat (4) @(negedge clk);
    chk({tag, "_an1"}, an, 3'b101);
    chk({tag, "_tens"}, seg, gt);
    repeat (4) @(negedge clk);
    chk({tag, "_an2"}, an, 3'b011);
    chk({tag, "_sign"}, seg, gs);
  endtask

  initial begin
    int lat, p1, p2, np, nv;
    logic rdy, s1, s2;
    logic [3:0] o1, o2, t2;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ovf = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_vals", {res_sign, res_tens, res_ones, res_err}, 10'd0);
    chk("rst_an", an, 3'b110);
    chk("rst_seg", seg, G0);
    @(negedge clk); rst_n = 1'b1;

    convert(5'b00111, 1'b0, lat);
    chk("p7_lat", lat, 6);
    check_res("p7", 1'b0, 4'd0, 4'd7, 1'b0);
    scan_chk("p7_scan", GB, G0, G7);

    convert(5'b10000, 1'b0, lat);
    chk("m16_lat", lat, 6);
    check_res("m16", 1'b1, 4'd1, 4'd6, 1'b0);
    scan_chk("m16_scan", GM, G1, G6);

    convert(5'b01010, 1'b1, lat);
    chk("ovf_lat", lat, 6);
    check_res("ovf", 1'b0, 4'd0, 4'd0, 1'b1);
    scan_chk("ovf_scan", GM, GE, GE);

    convert(5'b01100, 1'b0, lat);
    check_res("p12", 1'b0, 4'd1, 4'd2, 1'b0);
    scan_chk("p12_scan", GB, G1, G2);

    convert(5'b00000, 1'b0, lat);
    check_res("zero", 1'b0, 4'd0, 4'd0, 1'b0);

    // Back-to-back: +3 then -1 with in_valid held high across the conversion
    p1 = 0; p2 = 0; np = 0; s1 = 0; s2 = 0; o1 = 0; o2 = 0; t2 = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 5'b00011; in_ovf = 1'b0;
    rdy = in_ready;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_data = 5'b11111;
      if (c > 1 && rdy) in_valid = 1'b0;
      if (res_valid) begin
        np++;
        if (np == 1) begin p1 = c; s1 = res_sign; o1 = res_ones; end
        else begin p2 = c; s2 = res_sign; o2 = res_ones; t2 = res_tens; end
      end
      @(negedge clk); rdy = in_ready;
    end
    in_valid = 1'b0;
    chk("b2b_pulses", np, 2);
    chk("b2b_first_at", p1, 7);
    chk("b2b_gap", p2 - p1, 7);
    chk("b2b_first", {s1, o1}, {1'b0, 4'd3});
    chk("b2b_second", {s2, t2, o2}, {1'b1, 4'd0, 4'd1});

    // Reset in the middle of a conversion
    @(negedge clk);
    in_valid = 1'b1; in_data = 5'b01001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mid_ready", in_ready, 1'b1);
    chk("mid_vals", {res_valid, res_sign, res_tens, res_ones, res_err}, 11'd0);
    chk("mid_an", an, 3'b110);
    chk("mid_seg", seg, G0);
    @(negedge clk); rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (res_valid) nv++;
    end
    chk("mid_no_pulse", nv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
